pll_reset_sequencer: RTL and testbench

Control-side companion to the rPLL wrapper: drives the PLL's active-high RESET input, consumes its asynchronous LOCK output, and releases staged downstream resets only after lock has been continuously stable. It runs on the free-running crystal clock (27 MHz), which is the PLL input, not the PLL output, so it keeps operating while the PLL is unlocked. It sits at top level between the PLL instance and the per-domain reset synchronizers. It also recovers automatically from lock loss or a lock timeout by re-pulsing the PLL reset.

---
 rtl/pll_reset_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Drives the PLL RESET pin, watches the asynchronous PLL LOCK and releases the
// staged downstream resets only after lock has been continuously stable.
// Runs on the free-running crystal clock so it keeps working while the PLL is
// unlocked, and re-pulses the PLL reset after a lock loss.
// Optional build macro PLLSEQ_TIMEOUT_EN: when defined, WAIT_LOCK gives up after
// LOCK_TIMEOUT_CYCLES and re-pulses the PLL reset; when undefined the timeout
// counter is not built and WAIT_LOCK waits forever.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int STAGE_GAP           = 8,
    parameter int NSTAGES             = 3
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               lock,
    output logic               pll_reset,
    output logic [NSTAGES-1:0] rst_out_n,
    output logic               ready,
    output logic [7:0]         loss_count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Counters are sized one bit wider than $clog2 of their terminal count and
    // compare against terminal-1, so they never wrap.
    localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int GAP_W = $clog2(STAGE_GAP) + 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

`ifdef PLLSEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    // Elaboration-time parameter sanity checks.
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("LOCK_TIMEOUT_CYCLES must be at least 1");
    end
    if (PLL_RST_CYCLES < 1) begin : g_bad_pll_rst
        $error("PLL_RST_CYCLES must be at least 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("STAGE_GAP must be at least 1");
    end
    if ((NSTAGES < 1) || (NSTAGES > 8)) begin : g_bad_nstages
        $error("NSTAGES must be in 1..8");
    end

    // Saturating increment for the lock-loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        sat_inc8 = (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    logic                r_lock_meta;
    logic                r_lock_s;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [RST_W-1:0]    r_rst_cnt;
    logic [RST_W-1:0]    w_rst_cnt_nxt;
    logic [STB_W-1:0]    r_stb_cnt;
    logic [STB_W-1:0]    w_stb_cnt_nxt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [GAP_W-1:0]    w_gap_cnt_nxt;
`ifdef PLLSEQ_TIMEOUT_EN
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_cnt_nxt;
`endif

    logic                r_pll_reset;
    logic                w_pll_reset_nxt;
    logic [NSTAGES-1:0]  r_rst_out_n;
    logic [NSTAGES-1:0]  w_rst_out_n_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [7:0]          r_loss_count;
    logic [7:0]          w_loss_count_nxt;

    // Stage pattern after releasing the next bit (bit 0 first).
    logic [NSTAGES-1:0]  w_rst_shift;
    assign w_rst_shift = (r_rst_out_n << 1) | NSTAGES'(1);

    // Two-flop synchronizer for the asynchronous PLL LOCK.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET_PLL;
            r_rst_cnt    <= '0;
            r_stb_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_pll_reset  <= 1'b1;
            r_rst_out_n  <= '0;
            r_ready      <= 1'b0;
            r_loss_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_stb_cnt    <= w_stb_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_pll_reset  <= w_pll_reset_nxt;
            r_rst_out_n  <= w_rst_out_n_nxt;
            r_ready      <= w_ready_nxt;
            r_loss_count <= w_loss_count_nxt;
        end
    end

`ifdef PLLSEQ_TIMEOUT_EN
    // WAIT_LOCK timeout counter register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    // Next-state and output decode; every counter defaults to zero so it is
    // cleared on any state entry and only advances while its state persists.
    always_comb begin
        w_state_nxt      = r_state;
        w_rst_cnt_nxt    = '0;
        w_stb_cnt_nxt    = '0;
        w_gap_cnt_nxt    = '0;
`ifdef PLLSEQ_TIMEOUT_EN
        w_to_cnt_nxt     = '0;
`endif
        w_pll_reset_nxt  = r_pll_reset;
        w_rst_out_n_nxt  = r_rst_out_n;
        w_ready_nxt      = r_ready;
        w_loss_count_nxt = r_loss_count;

        case (r_state)
            RESET_PLL: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt     = WAIT_LOCK;
                    w_pll_reset_nxt = 1'b0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end

            WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = STABLE;
                end
`ifdef PLLSEQ_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt     = RESET_PLL;
                    w_pll_reset_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end

            STABLE: begin
                // A drop here is a glitch: back to WAIT_LOCK, no loss counted.
                // It also wins over a stable count terminating on this edge.
                if (!r_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_stb_cnt == STB_LAST) begin
                    w_rst_out_n_nxt = w_rst_shift;
                    if (w_rst_shift[NSTAGES-1]) begin
                        w_state_nxt = RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                end
            end

            RELEASE: begin
                // Loss wins over a stage release on the same edge.
                if (!r_lock_s) begin
                    w_state_nxt      = RESET_PLL;
                    w_pll_reset_nxt  = 1'b1;
                    w_rst_out_n_nxt  = '0;
                    w_ready_nxt      = 1'b0;
                    w_loss_count_nxt = sat_inc8(r_loss_count);
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_rst_out_n_nxt = w_rst_shift;
                    if (w_rst_shift[NSTAGES-1]) begin
                        w_state_nxt = RUN;
                        w_ready_nxt = 1'b1;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt      = RESET_PLL;
                    w_pll_reset_nxt  = 1'b1;
                    w_rst_out_n_nxt  = '0;
                    w_ready_nxt      = 1'b0;
                    w_loss_count_nxt = sat_inc8(r_loss_count);
                end
            end

            default: begin
                w_state_nxt     = RESET_PLL;
                w_pll_reset_nxt = 1'b1;
                w_rst_out_n_nxt = '0;
                w_ready_nxt     = 1'b0;
            end
        endcase
    end

    assign pll_reset  = r_pll_reset;
    assign rst_out_n  = r_rst_out_n;
    assign ready      = r_ready;
    assign loss_count = r_loss_count;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with the small test parameter set
// (stable 8, timeout 32, PLL reset 4, stage gap 2, 3 stages).
// Expectations follow PLLSEQ_TIMEOUT_EN the same way the design build does.
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STB  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       pll_reset;
    logic [2:0] rst_out_n;
    logic       ready;
    logic [7:0] loss_count;
    logic [2:0] state;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .PLL_RST_CYCLES     (4),
        .STAGE_GAP          (2),
        .NSTAGES            (3)
    ) dut (
        .clkin     (clk),
        .rst_n     (rst_n),
        .lock      (lock),
        .pll_reset (pll_reset),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .loss_count(loss_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Table record: after edge edge_n (counted from reset release) optionally
    // drive lock, and optionally expect the packed outputs on that edge.
    typedef struct packed {
        int          tbl;
        int          edge_n;
        bit          drv;
        logic        lk;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    typedef struct packed {
        int          cyc;
        int          tag;
        logic [15:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc;
    int   checks;
    int   failures;

    function automatic logic [15:0] pk(input logic p, input logic [2:0] r,
                                       input logic rd, input logic [7:0] l,
                                       input logic [2:0] s);
        pk = {p, r, rd, l, s};
    endfunction

    task automatic add(input int tbl, input int e, input bit drv, input logic lk,
                       input bit chk, input logic [15:0] exp);
        vecs.push_back('{tbl: tbl, edge_n: e, drv: drv, lk: lk, chk: chk, exp: exp});
    endtask

    task automatic compare(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = {pll_reset, rst_out_n, ready, loss_count, state};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got pll_reset=%b rst_out_n=%b ready=%b loss=%0d state=%0d; want pll_reset=%b rst_out_n=%b ready=%b loss=%0d state=%0d",
                     name, act[15], act[14:12], act[11], act[10:3], act[2:0],
                     exp[15], exp[14:12], exp[11], exp[10:3], exp[2:0]);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push_exp(input int at, input int tag, input logic [15:0] exp);
        sb.push_back('{cyc: at, tag: tag, exp: exp});
    endtask

    // Advance one clock and compare everything due on that edge.
    task automatic tick();
        sb_t ent;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent = sb.pop_front();
            compare($sformatf("vec%0d", ent.tag), ent.exp);
        end
    endtask

    task automatic run_table(input int tbl);
        int base;
        int last;
        base = cyc;
        last = 0;
        foreach (vecs[i]) begin
            if (vecs[i].tbl == tbl) begin
                if (vecs[i].chk)
                    push_exp(base + vecs[i].edge_n, tbl * 1000 + vecs[i].edge_n, vecs[i].exp);
                if (vecs[i].edge_n > last)
                    last = vecs[i].edge_n;
            end
        end
        for (int e = 1; e <= last; e++) begin
            tick();
            foreach (vecs[j]) begin
                if (vecs[j].tbl == tbl && vecs[j].edge_n == e && vecs[j].drv)
                    lock = vecs[j].lk;
            end
        end
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            tick();
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pll_reset(input int bound, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            tick();
            if (pll_reset === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int       base;
        bit       ok;
        logic [7:0] exp_loss;

        cyc      = 0;
        checks   = 0;
        failures = 0;

        // Table 1: power-up, lock at +10 after pll_reset falls, drop in RUN,
        // then lock held low.
        add(1,   1, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        add(1,   3, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        add(1,   4, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(1,  14, 1'b1, 1'b1, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(1,  16, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(1,  17, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(1,  24, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(1,  25, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b001, 1'b0, 8'd0, S_REL));
        add(1,  26, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b001, 1'b0, 8'd0, S_REL));
        add(1,  27, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b011, 1'b0, 8'd0, S_REL));
        add(1,  28, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b011, 1'b0, 8'd0, S_REL));
        add(1,  29, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b111, 1'b1, 8'd0, S_RUN));
        add(1,  32, 1'b1, 1'b0, 1'b1, pk(1'b0, 3'b111, 1'b1, 8'd0, S_RUN));
        add(1,  34, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b111, 1'b1, 8'd0, S_RUN));
        add(1,  35, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd1, S_RST));
        add(1,  38, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd1, S_RST));
        add(1,  39, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
        add(1,  70, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
`ifdef PLLSEQ_TIMEOUT_EN
        add(1,  71, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd1, S_RST));
        add(1,  75, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
        add(1, 106, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
        add(1, 107, 1'b0, 1'b0, 1'b1, pk(1'b1, 3'b000, 1'b0, 8'd1, S_RST));
`else
        add(1,  71, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
        add(1,  75, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
        add(1, 107, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd1, S_WAIT));
`endif

        // Table 2: lock glitch 5 cycles into STABLE; the drop lands on the
        // edge the stable count would terminate.
        add(2,   4, 1'b1, 1'b1, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(2,   6, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(2,   7, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(2,  12, 1'b1, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(2,  14, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(2,  15, 1'b1, 1'b1, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(2,  17, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        add(2,  18, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(2,  25, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        add(2,  26, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b001, 1'b0, 8'd0, S_REL));
        add(2,  28, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b011, 1'b0, 8'd0, S_REL));
        add(2,  30, 1'b0, 1'b0, 1'b1, pk(1'b0, 3'b111, 1'b1, 8'd0, S_RUN));

        // Reset state.
        lock  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 compare("reset_state", pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        tick();
        tick();
        compare("reset_hold", pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        rst_n = 1'b1;
        run_table(1);

        tick();
        rst_n = 1'b0;
        lock  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_table(2);

        // Async reset in the middle of RELEASE, then full restart.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base  = cyc;
        push_exp(base + 4,  3004, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        push_exp(base + 5,  3005, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        push_exp(base + 13, 3013, pk(1'b0, 3'b001, 1'b0, 8'd0, S_REL));
        push_exp(base + 15, 3015, pk(1'b0, 3'b011, 1'b0, 8'd0, S_REL));
        repeat (15) tick();
        #3 rst_n = 1'b0;
        #1 compare("async_reset_mid_release", pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        tick();
        tick();
        rst_n = 1'b1;
        base  = cyc;
        push_exp(base + 1,  4001, pk(1'b1, 3'b000, 1'b0, 8'd0, S_RST));
        push_exp(base + 4,  4004, pk(1'b0, 3'b000, 1'b0, 8'd0, S_WAIT));
        push_exp(base + 5,  4005, pk(1'b0, 3'b000, 1'b0, 8'd0, S_STB));
        push_exp(base + 13, 4013, pk(1'b0, 3'b001, 1'b0, 8'd0, S_REL));
        repeat (13) tick();

        // 300 lock losses from RUN; loss_count saturates at 255.
        exp_loss = 8'd0;
        for (int i = 1; i <= 300; i++) begin
            wait_ready(100, ok);
            if (!ok) begin
                timeout_fail($sformatf("wait_ready_%0d", i));
                break;
            end
            lock = 1'b0;
            wait_pll_reset(10, ok);
            if (!ok) begin
                timeout_fail($sformatf("wait_loss_%0d", i));
                break;
            end
            if (exp_loss != 8'hFF)
                exp_loss = exp_loss + 8'd1;
            if (i == 1 || i == 2 || i == 255 || i == 256 || i == 300)
                compare($sformatf("loss_%0d", i), pk(1'b1, 3'b000, 1'b0, exp_loss, S_RST));
            lock = 1'b1;
        end

        while (sb.size() > 0) begin
            void'(sb.pop_front());
            timeout_fail("sb_unconsumed");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
